// File: rtl/rcpu_pkg.sv
// Shared encodings for the rcpu memory arbiter.
//   ST_*     arbiter FSM states
//   TAG_*    read-return tag: which port owns next cycle's mem_rdata
//   STARVE_W width of the loader starvation counter (saturates at 15)
package rcpu_pkg;

  localparam int unsigned STARVE_W = 4;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_LOCK  = 2'd2;

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_CPU  = 2'd1;
  localparam logic [1:0] TAG_LD   = 2'd2;

endpackage

// File: rtl/rcpu_mem_arbiter.sv
// Single-port RAM arbiter for the rcpu core.
// Three requesters share one synchronous RAM: CPU write, CPU read and a
// loader/debug port. At most one access is granted per cycle. Acks are
// combinational. Read data returns one cycle after the grant. The loader can
// lock the RAM for exclusive use, which stalls the core.
// Ports:
//   clk, reset                      clock, async active-high reset
//   cpu_wr_req/addr/data/ack        CPU write channel
//   cpu_rd_req/addr/ack             CPU read request channel
//   cpu_rd_valid/data               CPU read return
//   cpu_stall                       core hold (lock pending or locked)
//   ld_req/we/addr/wdata/ack        loader access channel
//   ld_rd_valid/data                loader read return
//   ld_lock/ld_locked               exclusive ownership request/status
//   mem_en/we/addr/wdata/rdata      RAM interface
module rcpu_mem_arbiter
  import rcpu_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_wr_req,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic              cpu_wr_ack,
  input  logic              cpu_rd_req,
  input  logic [ADDR_W-1:0] cpu_rd_addr,
  output logic              cpu_rd_ack,
  output logic              cpu_rd_valid,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic              ld_rd_valid,
  output logic [DATA_W-1:0] ld_rd_data,
  input  logic              ld_lock,
  output logic              ld_locked,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [STARVE_W-1:0] StarveLim = STARVE_LIMIT[STARVE_W-1:0];

  logic [1:0]          state_q, state_d;
  logic [1:0]          tag_q, tag_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [DATA_W-1:0]   cpu_hold_q, ld_hold_q;
  logic                gnt_wr, gnt_rd, gnt_ld;
  logic                cpu_allowed;

  // Priority encoder and RAM mux. Combinational acks are gated by reset so
  // every output reads 0 while reset is held.
  always_comb begin
    gnt_wr = 1'b0;
    gnt_rd = 1'b0;
    gnt_ld = 1'b0;
    // Unlock cycle already arbitrates normally.
    cpu_allowed = (state_q == ST_RUN) || ((state_q == ST_LOCK) && !ld_lock);
    if (!reset) begin
      if (cpu_allowed) begin
        if (cpu_wr_req)                            gnt_wr = 1'b1;
        else if (ld_req && (starve_q >= StarveLim)) gnt_ld = 1'b1;
        else if (cpu_rd_req)                       gnt_rd = 1'b1;
        else if (ld_req)                           gnt_ld = 1'b1;
      end else if (ld_req) begin
        gnt_ld = 1'b1;
      end
    end

    cpu_wr_ack = gnt_wr;
    cpu_rd_ack = gnt_rd;
    ld_ack     = gnt_ld;

    mem_en    = gnt_wr | gnt_rd | gnt_ld;
    mem_we    = gnt_wr | (gnt_ld & ld_we);
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_wr) begin
      mem_addr  = cpu_wr_addr;
      mem_wdata = cpu_wr_data;
    end else if (gnt_rd) begin
      mem_addr  = cpu_rd_addr;
    end else if (gnt_ld) begin
      mem_addr  = ld_addr;
      if (ld_we) mem_wdata = ld_wdata;
    end

    cpu_stall = !reset && ((state_q == ST_DRAIN) || ((state_q == ST_LOCK) && ld_lock));
    ld_locked = !reset && (state_q == ST_LOCK) && ld_lock;

    cpu_rd_valid = (tag_q == TAG_CPU);
    ld_rd_valid  = (tag_q == TAG_LD);
    cpu_rd_data  = cpu_rd_valid ? mem_rdata : cpu_hold_q;
    ld_rd_data   = ld_rd_valid  ? mem_rdata : ld_hold_q;

    state_d = state_q;
    case (state_q)
      ST_RUN:   if (ld_lock) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ld_lock ? ST_LOCK : ST_RUN;
      ST_LOCK:  if (!ld_lock) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase

    if (gnt_rd)                tag_d = TAG_CPU;
    else if (gnt_ld && !ld_we) tag_d = TAG_LD;
    else                       tag_d = TAG_NONE;

    starve_d = starve_q;
    if (!ld_req || gnt_ld)      starve_d = '0;
    else if (starve_q != '1)    starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      tag_q      <= TAG_NONE;
      starve_q   <= '0;
      cpu_hold_q <= '0;
      ld_hold_q  <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      starve_q <= starve_d;
      // Capture the returned word so rd_data holds after the valid pulse.
      if (tag_q == TAG_CPU) cpu_hold_q <= mem_rdata;
      if (tag_q == TAG_LD)  ld_hold_q  <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_rcpu_mem_arbiter.sv
// Self-checking bench for rcpu_mem_arbiter: directed scenarios followed by a
// randomized phase checked against a cycle-level behavioural model.
module tb_rcpu_mem_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_wr_req, cpu_wr_ack, cpu_rd_req, cpu_rd_ack, cpu_rd_valid, cpu_stall;
  logic [AW-1:0] cpu_wr_addr, cpu_rd_addr, ld_addr, mem_addr;
  logic [DW-1:0] cpu_wr_data, cpu_rd_data, ld_wdata, ld_rd_data, mem_wdata, mem_rdata;
  logic          ld_req, ld_we, ld_ack, ld_rd_valid, ld_lock, ld_locked, mem_en, mem_we;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rcpu_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .cpu_wr_req(cpu_wr_req), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
    .cpu_wr_ack(cpu_wr_ack),
    .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr), .cpu_rd_ack(cpu_rd_ack),
    .cpu_rd_valid(cpu_rd_valid), .cpu_rd_data(cpu_rd_data), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack), .ld_rd_valid(ld_rd_valid), .ld_rd_data(ld_rd_data),
    .ld_lock(ld_lock), .ld_locked(ld_locked),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous single-port RAM environment.
  logic [DW-1:0] ram [0:65535];
  always @(posedge clk) begin
    if (mem_en && mem_we)  ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_wr_req = 0; cpu_wr_addr = '0; cpu_wr_data = '0;
    cpu_rd_req = 0; cpu_rd_addr = '0;
    ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0; ld_lock = 0;
  endtask

  task automatic test_reset();
    logic [8:0]      flags;
    logic [4*DW-1:0] buses;
    reset = 1;
    idle_inputs();
    cpu_rd_req = 1; cpu_rd_addr = 16'h0010; ld_req = 1;
    @(negedge clk);
    flags = {cpu_wr_ack, cpu_rd_ack, cpu_rd_valid, cpu_stall, ld_ack, ld_rd_valid,
             ld_locked, mem_en, mem_we};
    buses = {cpu_rd_data, ld_rd_data, mem_addr, mem_wdata};
    n_vec++; if (flags !== 9'b0) begin n_err++;
      $display("FAIL reset_flags got %b exp 0", flags); end
    n_vec++; if (buses !== '0) begin n_err++;
      $display("FAIL reset_buses got %h exp 0", buses); end
    step();
    reset = 0; ld_req = 0;
    @(negedge clk);
    n_vec++; if ({cpu_rd_ack, mem_en, mem_addr} !== {1'b1, 1'b1, 16'h0010}) begin n_err++;
      $display("FAIL rst_rd_ack got ack=%b en=%b addr=%h exp 1 1 0010",
               cpu_rd_ack, mem_en, mem_addr); end
    step();
    reset = 1;  // read tag captured on the edge just passed; reset must drop it
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      flags = {cpu_wr_ack, cpu_rd_ack, cpu_rd_valid, cpu_stall, ld_ack, ld_rd_valid,
               ld_locked, mem_en, mem_we};
      buses = {cpu_rd_data, ld_rd_data, mem_addr, mem_wdata};
      n_vec++; if ({flags, buses} !== '0) begin n_err++;
        $display("FAIL midrd_reset_outputs got %b %h exp all 0", flags, buses); end
      step();
    end
    reset = 0; cpu_rd_req = 0;
    @(negedge clk);
    n_vec++; if (cpu_rd_valid !== 1'b0) begin n_err++;
      $display("FAIL post_reset_rd_valid got %b exp 0", cpu_rd_valid); end
    step();
  endtask

  task automatic test_wr_rd_collision();
    cpu_wr_req = 1; cpu_wr_addr = 16'h0020; cpu_wr_data = 16'hBEEF;
    cpu_rd_req = 1; cpu_rd_addr = 16'h0020;
    @(negedge clk);
    n_vec++; if ({cpu_wr_ack, cpu_rd_ack, mem_we, mem_addr, mem_wdata} !==
                 {1'b1, 1'b0, 1'b1, 16'h0020, 16'hBEEF}) begin n_err++;
      $display("FAIL coll_cyc0 got wack=%b rack=%b we=%b a=%h d=%h exp 1 0 1 0020 beef",
               cpu_wr_ack, cpu_rd_ack, mem_we, mem_addr, mem_wdata); end
    step();
    cpu_wr_req = 0;
    @(negedge clk);
    n_vec++; if ({cpu_wr_ack, cpu_rd_ack, mem_en, mem_we, mem_addr} !==
                 {1'b0, 1'b1, 1'b1, 1'b0, 16'h0020}) begin n_err++;
      $display("FAIL coll_cyc1 got wack=%b rack=%b en=%b we=%b a=%h exp 0 1 1 0 0020",
               cpu_wr_ack, cpu_rd_ack, mem_en, mem_we, mem_addr); end
    step();
    cpu_rd_req = 0;
    @(negedge clk);
    n_vec++; if ({cpu_rd_valid, cpu_rd_data} !== {1'b1, 16'hBEEF}) begin n_err++;
      $display("FAIL coll_cyc2 got v=%b d=%h exp 1 beef", cpu_rd_valid, cpu_rd_data); end
    step();
    @(negedge clk);
    n_vec++; if ({cpu_rd_valid, cpu_rd_data, mem_en} !== {1'b0, 16'hBEEF, 1'b0}) begin n_err++;
      $display("FAIL coll_hold got v=%b d=%h en=%b exp 0 beef 0",
               cpu_rd_valid, cpu_rd_data, mem_en); end
    step();
  endtask

  task automatic test_starvation();
    ld_req = 1; ld_we = 0; ld_addr = 16'h0020;
    cpu_rd_req = 1; cpu_rd_addr = 16'h0020;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_vec++; if ({ld_ack, cpu_rd_ack} !== {c == 4, c != 4}) begin n_err++;
        $display("FAIL starve_acks cyc %0d got ld=%b rd=%b exp ld=%b rd=%b",
                 c, ld_ack, cpu_rd_ack, c == 4, c != 4); end
      if (c == 5) begin
        n_vec++; if ({ld_rd_valid, ld_rd_data, cpu_rd_valid} !== {1'b1, 16'hBEEF, 1'b0})
        begin n_err++;
          $display("FAIL starve_ld_ret got v=%b d=%h cv=%b exp 1 beef 0",
                   ld_rd_valid, ld_rd_data, cpu_rd_valid); end
      end
      step();
      if (c == 4) ld_req = 0;
    end
    cpu_rd_req = 0;
  endtask

  task automatic test_lock();
    cpu_rd_req = 1; cpu_rd_addr = 16'h0020; ld_lock = 1;
    @(negedge clk);
    n_vec++; if ({cpu_rd_ack, ld_locked} !== 2'b10) begin n_err++;
      $display("FAIL lock_cyc0 got ack=%b locked=%b exp 1 0", cpu_rd_ack, ld_locked); end
    step();
    cpu_rd_req = 0;
    @(negedge clk);
    n_vec++; if ({cpu_rd_valid, cpu_rd_data, cpu_stall, ld_locked} !==
                 {1'b1, 16'hBEEF, 1'b1, 1'b0}) begin n_err++;
      $display("FAIL lock_cyc1 got v=%b d=%h stall=%b locked=%b exp 1 beef 1 0",
               cpu_rd_valid, cpu_rd_data, cpu_stall, ld_locked); end
    step();
    @(negedge clk);
    n_vec++; if ({cpu_rd_valid, cpu_stall, ld_locked} !== 3'b011) begin n_err++;
      $display("FAIL lock_cyc2 got v=%b stall=%b locked=%b exp 0 1 1",
               cpu_rd_valid, cpu_stall, ld_locked); end
    step();
  endtask

  task automatic test_locked_load();
    cpu_wr_req = 1; cpu_wr_addr = 16'h0050; cpu_wr_data = 16'hAAAA;
    for (int i = 0; i < 4; i++) begin
      ld_req = 1; ld_we = 1; ld_addr = AW'(i); ld_wdata = DW'(16'h1234 + i);
      @(negedge clk);
      n_vec++; if ({ld_ack, cpu_wr_ack, mem_we, mem_addr, mem_wdata, ld_locked, ld_rd_valid}
                   !== {1'b1, 1'b0, 1'b1, AW'(i), DW'(16'h1234 + i), 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL load_wr %0d got ack=%b wack=%b we=%b a=%h d=%h lk=%b v=%b", i,
                 ld_ack, cpu_wr_ack, mem_we, mem_addr, mem_wdata, ld_locked, ld_rd_valid); end
      step();
    end
    ld_we = 0; ld_addr = 16'h0002;
    @(negedge clk);
    n_vec++; if ({ld_ack, cpu_wr_ack, mem_en, mem_we, ld_rd_valid} !== 5'b10100) begin n_err++;
      $display("FAIL load_rd_ack got ack=%b wack=%b en=%b we=%b v=%b exp 1 0 1 0 0",
               ld_ack, cpu_wr_ack, mem_en, mem_we, ld_rd_valid); end
    step();
    ld_req = 0;
    @(negedge clk);
    n_vec++; if ({ld_rd_valid, ld_rd_data, cpu_wr_ack} !== {1'b1, 16'h1236, 1'b0}) begin
      n_err++;
      $display("FAIL load_rd_ret got v=%b d=%h wack=%b exp 1 1236 0",
               ld_rd_valid, ld_rd_data, cpu_wr_ack); end
    step();
    cpu_wr_req = 0;
  endtask

  task automatic test_unlock();
    cpu_rd_req = 1; cpu_rd_addr = 16'h0003;
    @(negedge clk);
    n_vec++; if ({cpu_rd_ack, cpu_stall, ld_locked} !== 3'b011) begin n_err++;
      $display("FAIL unlock_pre got ack=%b stall=%b locked=%b exp 0 1 1",
               cpu_rd_ack, cpu_stall, ld_locked); end
    step();
    ld_lock = 0;
    @(negedge clk);
    n_vec++; if ({cpu_rd_ack, cpu_stall, ld_locked} !== 3'b100) begin n_err++;
      $display("FAIL unlock_cyc got ack=%b stall=%b locked=%b exp 1 0 0",
               cpu_rd_ack, cpu_stall, ld_locked); end
    step();
    cpu_rd_req = 0;
    @(negedge clk);
    n_vec++; if ({cpu_rd_valid, cpu_rd_data, cpu_stall} !== {1'b1, 16'h1237, 1'b0}) begin
      n_err++;
      $display("FAIL unlock_ret got v=%b d=%h stall=%b exp 1 1237 0",
               cpu_rd_valid, cpu_rd_data, cpu_stall); end
    step();
  endtask

  // Model: lock mode follows from how many consecutive cycles ld_lock has been
  // high before the current one (0: normal, 1: draining, 2+: exclusive).
  task automatic test_random();
    logic [DW-1:0] shadow [int];
    int            lock_run = 0, ld_wait = 0, win = 0;
    bit            pend_cpu = 0, pend_ld = 0, pc_known = 0, pl_known = 0;
    logic [DW-1:0] pc_data = '0, pl_data = '0;
    bit            lc_known = 1, ll_known = 1;
    logic [DW-1:0] lc_data = 16'h1237, ll_data = 16'h1236;
    bit            cpu_ok, stall_e, locked_e, we_e, en_e;
    logic [AW-1:0] addr_e;
    logic [DW-1:0] wdata_e;
    logic [8:0]    got, exp;
    for (int i = 0; i < 4; i++) shadow[i] = DW'(16'h1234 + i);
    shadow[32] = 16'hBEEF;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (win == 1) cpu_wr_req = 0;
      if (win == 2) cpu_rd_req = 0;
      if (win == 3) ld_req = 0;
      if (!cpu_wr_req && $urandom_range(0, 2) == 0) begin
        cpu_wr_req = 1; cpu_wr_addr = AW'($urandom_range(0, 7)); cpu_wr_data = DW'($urandom);
      end
      if (!cpu_rd_req && $urandom_range(0, 1) == 0) begin
        cpu_rd_req = 1; cpu_rd_addr = AW'($urandom_range(0, 7));
      end
      if (!ld_req && $urandom_range(0, 2) == 0) begin
        ld_req = 1; ld_we = 1'($urandom_range(0, 1));
        ld_addr = AW'($urandom_range(0, 7)); ld_wdata = DW'($urandom);
      end
      if ($urandom_range(0, 9) == 0) ld_lock = !ld_lock;
      @(negedge clk);

      cpu_ok   = (lock_run == 0) || (lock_run >= 2 && !ld_lock);
      stall_e  = (lock_run == 1) || (lock_run >= 2 && ld_lock);
      locked_e = (lock_run >= 2) && ld_lock;
      if (cpu_ok) begin
        if (cpu_wr_req)                     win = 1;
        else if (ld_req && ld_wait >= LIM)  win = 3;
        else if (cpu_rd_req)                win = 2;
        else if (ld_req)                    win = 3;
        else                                win = 0;
      end else begin
        win = ld_req ? 3 : 0;
      end
      en_e    = (win != 0);
      we_e    = (win == 1) || (win == 3 && ld_we);
      addr_e  = (win == 1) ? cpu_wr_addr : (win == 2) ? cpu_rd_addr :
                (win == 3) ? ld_addr : '0;
      wdata_e = (win == 1) ? cpu_wr_data : ld_wdata;

      got = {cpu_wr_ack, cpu_rd_ack, ld_ack, mem_en, mem_we, cpu_stall, ld_locked,
             cpu_rd_valid, ld_rd_valid};
      exp = {win == 1, win == 2, win == 3, en_e, we_e, stall_e, locked_e, pend_cpu, pend_ld};
      n_vec++; if (got !== exp) begin n_err++;
        $display("FAIL rnd_ctrl cyc %0d got %b exp %b (wa ra la en we st lk cv lv)",
                 cyc, got, exp); end
      if (en_e) begin
        n_vec++; if (mem_addr !== addr_e) begin n_err++;
          $display("FAIL rnd_addr cyc %0d got %h exp %h", cyc, mem_addr, addr_e); end
      end
      if (we_e) begin
        n_vec++; if (mem_wdata !== wdata_e) begin n_err++;
          $display("FAIL rnd_wdata cyc %0d got %h exp %h", cyc, mem_wdata, wdata_e); end
      end
      if (pend_cpu) begin lc_known = pc_known; lc_data = pc_data; end
      if (pend_ld)  begin ll_known = pl_known; ll_data = pl_data; end
      if (lc_known) begin
        n_vec++; if (cpu_rd_data !== lc_data) begin n_err++;
          $display("FAIL rnd_cpu_data cyc %0d got %h exp %h", cyc, cpu_rd_data, lc_data); end
      end
      if (ll_known) begin
        n_vec++; if (ld_rd_data !== ll_data) begin n_err++;
          $display("FAIL rnd_ld_data cyc %0d got %h exp %h", cyc, ld_rd_data, ll_data); end
      end

      pend_cpu = (win == 2);
      pend_ld  = (win == 3) && !ld_we;
      if (pend_cpu) begin
        pc_known = shadow.exists(int'(cpu_rd_addr)) != 0;
        pc_data  = pc_known ? shadow[int'(cpu_rd_addr)] : '0;
      end
      if (pend_ld) begin
        pl_known = shadow.exists(int'(ld_addr)) != 0;
        pl_data  = pl_known ? shadow[int'(ld_addr)] : '0;
      end
      if (win == 1) shadow[int'(cpu_wr_addr)] = cpu_wr_data;
      if (win == 3 && ld_we) shadow[int'(ld_addr)] = ld_wdata;
      if (ld_req && win != 3) ld_wait = (ld_wait < 15) ? ld_wait + 1 : 15;
      else                    ld_wait = 0;
      lock_run = ld_lock ? ((lock_run < 1000) ? lock_run + 1 : 1000) : 0;
      step();
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_wr_rd_collision();
    test_starvation();
    test_lock();
    test_locked_load();
    test_unlock();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
